// File: rtl/pin_scan_ctrl.sv
// Pin-scan sequencer: announces each pin's ball label over UART, then blinks only that pin for a dwell time.
// Latency: all outputs registered; tx_done_i is acted on at the 3rd clk_i edge after it rises.
// Backpressure: each byte is held with tx_send_o high until done; PIN_SCAN_MANUAL_EN ends each dwell on step_i.
module pin_scan_ctrl #(
    parameter int NUM_PINS     = 8,
    parameter int DWELL_CYCLES = 25000000,
    parameter int BLINK_HALF   = 2500000,
    parameter int CNT_W        = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    step_i,
    input  logic [16*NUM_PINS-1:0]  pin_label_i,
    output logic [NUM_PINS-1:0]     pins_o,
    output logic [7:0]              tx_byte_o,
    output logic                    tx_send_o,
    input  logic                    tx_done_i,
    output logic [7:0]              cur_idx_o,
    output logic                    scan_wrap_o
);

    typedef enum logic [1:0] {IDLE, ANNOUNCE, DWELL} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             byte_q, byte_d;
    logic [CNT_W-1:0]       dwell_q, dwell_d;
    logic [CNT_W-1:0]       blink_q, blink_d;
    logic                   lvl_q, lvl_d;
    logic                   stop_q, stop_d;
    logic [7:0]             idx_d;
    logic [7:0]             tx_byte_d;
    logic                   tx_send_d;
    logic                   wrap_d;
    logic [NUM_PINS-1:0]    pins_d;
    logic [NUM_PINS-1:0]    sel_mask;
    logic [15:0]            label;
    logic                   done_s1, done_s2, done_s3;
    logic                   done_evt;
    logic                   dwell_end;

    // tx_done_i may come from the baud-clock domain
    assign done_evt = done_s2 & ~done_s3;

`ifdef PIN_SCAN_MANUAL_EN
    assign dwell_end = step_i;
    logic unused_dwell;
    assign unused_dwell = ^dwell_q;
`else
    assign dwell_end = (dwell_q == CNT_W'(DWELL_CYCLES - 1));
    logic unused_step;
    assign unused_step = step_i;
`endif

    always_comb begin
        idx_d  = cur_idx_o;
        wrap_d = 1'b0;
        if (state_q == DWELL && dwell_end) begin
            if (cur_idx_o == 8'(NUM_PINS - 1)) begin
                idx_d  = 8'd0;
                wrap_d = 1'b1;
            end else begin
                idx_d = cur_idx_o + 8'd1;
            end
        end
    end

    // Label follows the index being loaded, so a dwell exit announces the new pin
    always_comb begin
        label = pin_label_i[15:0];
        for (int i = 1; i < NUM_PINS; i++) begin
            if (idx_d == 8'(i)) label = pin_label_i[16*i +: 16];
        end
    end

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            sel_mask[i] = (cur_idx_o == 8'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        dwell_d   = dwell_q;
        blink_d   = blink_q;
        lvl_d     = lvl_q;
        stop_d    = 1'b0;
        tx_byte_d = tx_byte_o;
        tx_send_d = tx_send_o;
        pins_d    = '0;
        case (state_q)
            IDLE: begin
                tx_send_d = 1'b0;
                if (enable_i) begin
                    state_d   = ANNOUNCE;
                    tx_byte_d = label[15:8];
                    tx_send_d = 1'b1;
                    byte_d    = 2'd0;
                end
            end
            ANNOUNCE: begin
                // A drop of enable_i lets the byte on the wire finish, then parks in IDLE
                stop_d = stop_q | ~enable_i;
                if (done_evt) begin
                    if (stop_d) begin
                        state_d   = IDLE;
                        tx_send_d = 1'b0;
                        byte_d    = 2'd0;
                    end else if (byte_q == 2'd3) begin
                        state_d   = DWELL;
                        tx_send_d = 1'b0;
                        pins_d    = sel_mask;
                        dwell_d   = '0;
                        blink_d   = '0;
                        lvl_d     = 1'b1;
                    end else begin
                        byte_d = byte_q + 2'd1;
                        case (byte_q)
                            2'd0:    tx_byte_d = label[7:0];
                            2'd1:    tx_byte_d = 8'h0D;
                            default: tx_byte_d = 8'h0A;
                        endcase
                    end
                end
            end
            DWELL: begin
                if (dwell_end) begin
                    dwell_d = '0;
                    blink_d = '0;
                    byte_d  = 2'd0;
                    if (enable_i) begin
                        state_d   = ANNOUNCE;
                        tx_byte_d = label[15:8];
                        tx_send_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!enable_i) begin
                    state_d = IDLE;
                end else begin
`ifndef PIN_SCAN_MANUAL_EN
                    dwell_d = dwell_q + 1'b1;
`endif
                    if (blink_q == CNT_W'(BLINK_HALF - 1)) begin
                        blink_d = '0;
                        lvl_d   = ~lvl_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                    pins_d = sel_mask & {NUM_PINS{lvl_d}};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            byte_q      <= 2'd0;
            dwell_q     <= '0;
            blink_q     <= '0;
            lvl_q       <= 1'b0;
            stop_q      <= 1'b0;
            done_s1     <= 1'b0;
            done_s2     <= 1'b0;
            done_s3     <= 1'b0;
            pins_o      <= '0;
            tx_byte_o   <= 8'h00;
            tx_send_o   <= 1'b0;
            cur_idx_o   <= 8'd0;
            scan_wrap_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            dwell_q     <= dwell_d;
            blink_q     <= blink_d;
            lvl_q       <= lvl_d;
            stop_q      <= stop_d;
            done_s1     <= tx_done_i;
            done_s2     <= done_s1;
            done_s3     <= done_s2;
            pins_o      <= pins_d;
            tx_byte_o   <= tx_byte_d;
            tx_send_o   <= tx_send_d;
            cur_idx_o   <= idx_d;
            scan_wrap_o <= wrap_d;
        end
    end

endmodule
